// File: rtl/seq_detector_1011.sv
// ---------------------------------------------------------------------------
// seq_detector_1011
//
// Moore detector for the serial pattern 1011, with overlapping matches.
// It reads the registered serial bit from the upstream async-reset FFD stage
// and keeps a saturating count of how many matches it has seen.
//
// Ports:
//   clk          rising-edge clock, shared with the upstream FFD
//   reset_async  asynchronous active-low reset; forces S0 and count = 0
//   data         serial input bit, already registered upstream
//   enable       1 = consume data on this edge, 0 = hold all FSM state
//   clear_cnt    synchronous clear of count; wins over a same-edge increment
//   detect       high while the FSM sits in the accepting state S4
//   count        detections since reset or clear, saturating at all-ones
//   state        current FSM state code, exposed for debug
// ---------------------------------------------------------------------------
module seq_detector_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             data,
  input  logic             enable,
  input  logic             clear_cnt,
  output logic             detect,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q;
  state_t state_nxt;
  logic   state_illegal;

  // Next-state decode. Each state is named after the longest pattern prefix
  // that is also a suffix of the bits seen so far. The S4 exits are the
  // overlap cases: a trailing "1" or "10" can start the next match.
  // Codes 5..7 are flagged so the register can recover from them.
  always_comb begin
    state_nxt     = S0;
    state_illegal = 1'b0;
    case (state_q)
      S0:      state_nxt = data ? S1 : S0;
      S1:      state_nxt = data ? S1 : S2;
      S2:      state_nxt = data ? S3 : S0;
      S3:      state_nxt = data ? S4 : S2;
      S4:      state_nxt = data ? S1 : S2;
      default: state_illegal = 1'b1;
    endcase
  end

  // State, detect and count all live in one register block.
  // detect is loaded with the decode of the state being entered, which keeps
  // it equal to (state == S4) without a path from data to the output.
  // An illegal code returns to S0 even while enable is low.
  // clear_cnt ignores enable and beats any same-edge increment.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      state_q <= S0;
      detect  <= 1'b0;
      count   <= '0;
    end else begin
      if (state_illegal) begin
        state_q <= S0;
        detect  <= 1'b0;
      end else if (enable) begin
        state_q <= state_nxt;
        detect  <= (state_nxt == S4);
      end

      if (clear_cnt) begin
        count <= '0;
      end else if (enable && !state_illegal && (state_nxt == S4) &&
                   (count != CNT_MAX)) begin
        count <= count + CNT_ONE;
      end
    end
  end

  assign state = state_q;

endmodule
